// File: rtl/iter_mult_if.sv
// Handshake and operand/result bundle for the iterative multiplier.
// The master side issues operands and start/flush; the slave side returns busy/done/product.
interface iter_mult_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             isSigned;
  logic [WIDTH-1:0] fbusA;
  logic [WIDTH-1:0] fbusB;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] prodLo;
  logic [WIDTH-1:0] prodHi;

  modport master (
    output start, isSigned, fbusA, fbusB, flush,
    input  busy, done, prodLo, prodHi
  );

  modport slave (
    input  start, isSigned, fbusA, fbusB, flush,
    output busy, done, prodLo, prodHi
  );
endinterface

// File: rtl/iter_mult_unit.sv
// Radix-2 shift-add multiplier, one multiplier bit per cycle.
// Signed operands are reduced to magnitudes on acceptance and the sign is
// reapplied to the full-width accumulator in the final cycle.
//
// state | meaning
// IDLE  | waiting for start; outputs hold the last completed product
// RUN   | WIDTH add/shift iterations
// FIN   | apply sign, publish product, pulse done
module iter_mult_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  iter_mult_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t             state_q, state_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               neg_q, neg_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;

  logic [WIDTH-1:0]   mag_a, mag_b;
  logic               a_neg, b_neg;

  // Operand magnitudes; 0x80..0 negates to itself, which read unsigned is 2**(WIDTH-1).
  always_comb begin
    a_neg = bus.isSigned & bus.fbusA[WIDTH-1];
    b_neg = bus.isSigned & bus.fbusB[WIDTH-1];
    mag_a = a_neg ? (~bus.fbusA + 1'b1) : bus.fbusA;
    mag_b = b_neg ? (~bus.fbusB + 1'b1) : bus.fbusB;
  end

  // Next-state, datapath and output computation.
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    prod_d   = prod_q;

    case (state_q)
      S_IDLE: begin
        // flush beats a simultaneous start
        if (bus.start && !bus.flush) begin
          mcand_d  = {{WIDTH{1'b0}}, mag_a};
          mplier_d = mag_b;
          // a zero operand must never produce a negated (still zero) result path
          neg_d    = (a_neg ^ b_neg) & (|bus.fbusA) & (|bus.fbusB);
          acc_d    = '0;
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        if (bus.flush) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          // mcand_q already carries the shift by cnt_q
          if (mplier_q[0]) acc_d = acc_q + mcand_q;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) state_d = S_FIN;
        end
      end
      S_FIN: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
        if (!bus.flush) begin
          prod_d = neg_q ? (~acc_q + 1'b1) : acc_q;
          done_d = 1'b1;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      prod_q   <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      prod_q   <= prod_d;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.prodLo = prod_q[WIDTH-1:0];
  assign bus.prodHi = prod_q[2*WIDTH-1:WIDTH];

endmodule

// File: tb/tb_iter_mult_unit.sv
// Directed bench for iter_mult_unit: stimulus pushes expected products into
// a queue; a monitor pops and compares on every done pulse.
module tb_iter_mult_unit;

  localparam int WIDTH = 32;

  logic clk;
  logic rst_n;

  iter_mult_if #(.WIDTH(WIDTH)) bus ();

  iter_mult_unit #(.WIDTH(WIDTH), .CNT_W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total = 0;
  int accepted = 0;
  int done_cnt = 0;
  logic [63:0] exp_q[$];
  logic [63:0] last_prod = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_done: got product %h expected no done", {bus.prodHi, bus.prodLo});
      end else begin
        check("product", {bus.prodHi, bus.prodLo}, exp_q.pop_front());
      end
    end
  end

  // Issues one multiply at the current negedge and follows it to its done pulse.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                        input logic [63:0] exp, input bit poke_start);
    int cyc;
    int busy_cnt;
    bit got;
    bus.start    = 1'b1;
    bus.fbusA    = a;
    bus.fbusB    = b;
    bus.isSigned = sgn;
    exp_q.push_back(exp);
    accepted++;
    cyc = 0;
    busy_cnt = 0;
    got = 0;
    while (!got && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        bus.start    = 1'b0;
        bus.fbusA    = $urandom;
        bus.fbusB    = $urandom;
        bus.isSigned = ~sgn;
      end
      if (poke_start && cyc == 5) bus.start = 1'b1;
      if (poke_start && cyc == 6) bus.start = 1'b0;
      if (bus.busy === 1'b1) busy_cnt++;
      if (bus.done === 1'b1) got = 1;
      if (cyc == WIDTH / 2) check("held_result", {bus.prodHi, bus.prodLo}, last_prod);
    end
    check("latency", 64'(cyc), 64'(WIDTH + 2));
    check("busy_cycles", 64'(busy_cnt), 64'(WIDTH + 1));
    last_prod = exp;
  endtask

  // Accepts an operation that the bench will abort; no expectation is queued.
  task automatic start_only(input logic [31:0] a, input logic [31:0] b);
    bus.start    = 1'b1;
    bus.fbusA    = a;
    bus.fbusB    = b;
    bus.isSigned = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.flush    = 1'b0;
    bus.isSigned = 1'b0;
    bus.fbusA    = '0;
    bus.fbusB    = '0;
    repeat (2) @(negedge clk);
    check("reset_busy", 64'(bus.busy), 64'd0);
    check("reset_done", 64'(bus.done), 64'd0);
    check("reset_prod", {bus.prodHi, bus.prodLo}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(32'd2, 32'd8, 1'b0, 64'h0000_0000_0000_0010, 1'b0);
    @(negedge clk);
    run_op(32'd2, 32'hFFFF_FFF8, 1'b1, 64'hFFFF_FFFF_FFFF_FFF0, 1'b0);
    run_op(32'd2, 32'hFFFF_FFF8, 1'b0, 64'h0000_0001_FFFF_FFF0, 1'b0);
    @(negedge clk);
    run_op(32'd35, 32'hFFFF_FFF8, 1'b1, 64'hFFFF_FFFF_FFFF_FEE8, 1'b0);
    // back-to-back: start driven on the done cycle
    run_op(32'd1000, 32'd2000, 1'b1, 64'h0000_0000_001E_8480, 1'b0);
    @(negedge clk);
    run_op(32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, 1'b0);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, 1'b0);
    run_op(32'hFFFF_FFFF, 32'd0, 1'b1, 64'h0, 1'b0);
    run_op(32'hFFFF_FFFD, 32'hFFFF_FFFB, 1'b1, 64'd15, 1'b0);
    @(negedge clk);
    run_op(32'd7, 32'd9, 1'b0, 64'd63, 1'b1);
    @(negedge clk);

    // flush mid-run: accepted at E0, flush sampled on the edge after cycle 10
    start_only(32'd7, 32'd9);
    repeat (9) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    check("flush_busy", 64'(bus.busy), 64'd0);
    check("flush_done", 64'(bus.done), 64'd0);
    check("flush_prod", {bus.prodHi, bus.prodLo}, last_prod);
    repeat (40) @(negedge clk);

    // flush and start together in IDLE: start dropped
    bus.flush = 1'b1;
    start_only(32'd4, 32'd4);
    bus.flush = 1'b0;
    check("flush_start_busy", 64'(bus.busy), 64'd0);
    repeat (40) @(negedge clk);

    // asynchronous reset between edges mid-run
    start_only(32'd9, 32'd9);
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_busy", 64'(bus.busy), 64'd0);
    check("async_rst_done", 64'(bus.done), 64'd0);
    check("async_rst_prod", {bus.prodHi, bus.prodLo}, 64'd0);
    last_prod = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(32'd3, 32'd5, 1'b0, 64'd15, 1'b0);

    repeat (5) @(negedge clk);
    check("done_count", 64'(done_cnt), 64'(accepted));
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
